// File: rtl/lcb_responder_if.sv
// LCB responder bus bundle: received-byte strobe, answer RAM read port,
// RS485 serial line with direction controls, and status pulses.
interface lcb_responder_if;
  logic [7:0] iData;
  logic       iValid;
  logic [7:0] iRdData;
  logic [7:0] oRdAddr;
  logic       oRdEn;
  logic       tx;
  logic       dirTX;
  logic       dirRX;
  logic       oBusy;
  logic       oDone;
  logic       oErr;

  modport master (
    output iData, iValid, iRdData,
    input  oRdAddr, oRdEn, tx, dirTX, dirRX, oBusy, oDone, oErr
  );

  modport slave (
    input  iData, iValid, iRdData,
    output oRdAddr, oRdEn, tx, dirTX, dirRX, oBusy, oDone, oErr
  );
endinterface

// File: rtl/lcb_responder.sv
// LCB stand-in: validates a request frame from uartRx, waits a turnaround
// gap, then serializes a fixed-length answer (8N1, LSB first) fetched from a
// sync-read answer RAM, with RS485 driver control around the answer.
module lcb_responder #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          REQ_BYTES    = 4,
  parameter int          RESP_BYTES   = 16,
  parameter logic [7:0]  DEV_ADDR     = 8'h01,
  parameter int          TURN_CLKS    = 80,
  parameter int          TIMEOUT_CLKS = 400
) (
  input  logic           clk,
  input  logic           rst,
  lcb_responder_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_TURN, S_LOAD, S_SEND, S_GUARD} state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  // Read issued three clocks before the stop bit ends: rd_en, RAM latency, latch.
  localparam logic [15:0] RD_ISSUE  = 16'(CLKS_PER_BIT - 3);
  localparam logic [15:0] TURN_LAST = 16'(TURN_CLKS - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]  REQ_LAST  = 8'(REQ_BYTES - 1);
  localparam logic [7:0]  RESP_LAST = 8'(RESP_BYTES - 1);

  state_t      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;          // gap / turnaround / bit timer
  logic [7:0]  cnt_q, cnt_d;          // request byte count, then answer byte index
  logic [3:0]  bit_q, bit_d;          // 0 start, 1..8 data, 9 stop
  logic        rd_en_q, rd_en_d;
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic        latch_q;               // RAM data valid this cycle
  logic        tx_q, tx_d;
  logic        dir_q, dir_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  sh_q, sh_d;

  // Next-state and output decode for the request/answer sequencer.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    tx_d      = tx_q;
    dir_d     = dir_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    base_d    = base_q;
    sh_d      = sh_q;

    // A byte arriving while the answer is in progress is dropped and flagged.
    if (bus.iValid && (state_q inside {S_TURN, S_LOAD, S_SEND, S_GUARD})) err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.iValid && (bus.iData == DEV_ADDR)) begin
          state_d = S_RECV;
          cnt_d   = 8'd1;
          tmr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RECV: begin
        // A byte on the expiry cycle wins over the timeout.
        if (bus.iValid) begin
          cnt_d = cnt_q + 8'd1;
          tmr_d = '0;
          if (cnt_q == 8'd1) base_d = bus.iData;
          if (cnt_q == REQ_LAST) state_d = S_TURN;
        end else if (tmr_q == TMO_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_TURN: begin
        if (tmr_q == TURN_LAST) begin
          state_d = S_LOAD;
          tmr_d   = '0;
          cnt_d   = '0;
          dir_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_LOAD: begin
        // Line held idle-high for one bit time with the driver on, then fetch byte 0.
        tmr_d = tmr_q + 16'd1;
        if (tmr_q == BIT_LAST) begin
          rd_en_d   = 1'b1;
          rd_addr_d = base_q;
        end
        if (latch_q) begin
          sh_d    = bus.iRdData;
          tx_d    = 1'b0;
          bit_d   = '0;
          tmr_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tmr_d = tmr_q + 16'd1;
        // Next byte is fetched during the stop bit so bytes go out back-to-back.
        if ((bit_q == 4'd9) && (tmr_q == RD_ISSUE) && (cnt_q != RESP_LAST)) begin
          rd_en_d   = 1'b1;
          rd_addr_d = base_q + cnt_q + 8'd1;
        end
        if (tmr_q == BIT_LAST) begin
          tmr_d = '0;
          if (bit_q == 4'd9) begin
            if (cnt_q == RESP_LAST) begin
              state_d = S_GUARD;
            end else begin
              cnt_d = cnt_q + 8'd1;
              sh_d  = bus.iRdData;
              tx_d  = 1'b0;
              bit_d = '0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = (bit_q == 4'd8) ? 1'b1 : sh_q[bit_q[2:0]];
          end
        end
      end
      S_GUARD: begin
        if (tmr_q == BIT_LAST) begin
          dir_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state; reset drives the line idle and releases the RS485 driver at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      latch_q   <= 1'b0;
      tx_q      <= 1'b1;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      latch_q   <= rd_en_q;
      tx_q      <= tx_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Data registers carry no reset; they are always written before being used.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    sh_q   <= sh_d;
  end

  assign bus.oRdAddr = rd_addr_q;
  assign bus.oRdEn   = rd_en_q;
  assign bus.tx      = tx_q;
  assign bus.dirTX   = dir_q;
  assign bus.dirRX   = dir_q;
  assign bus.oBusy   = busy_q;
  assign bus.oDone   = done_q;
  assign bus.oErr    = err_q;

endmodule

// File: tb/tb_lcb_responder.sv
// Bench for lcb_responder: random RAM contents and request timing, a serial
// line receiver, and an expected answer built from the request rules.
`timescale 1ns/1ps
module tb_lcb_responder;
  localparam int CPB       = 16;
  localparam int TURN      = 80;
  localparam int TMO       = 400;
  localparam int RESP      = 16;
  localparam int FIRST_LAT = TURN + CPB + 2;
  localparam int BYTE_CLKS = 10 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_iv = 0;
  int   stop_bad = 0;
  logic prev_dir = 1'b0;

  logic [7:0] ram [256];
  int         start_cyc[$];
  int         err_cyc[$];
  int         done_cyc[$];
  int         dfall_cyc[$];
  logic [7:0] rx_byte[$];
  logic [7:0] addr_log[$];

  lcb_responder_if bus();

  lcb_responder #(
    .CLKS_PER_BIT(CPB), .REQ_BYTES(4), .RESP_BYTES(RESP), .DEV_ADDR(8'h01),
    .TURN_CLKS(TURN), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  always #6 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sync-read answer RAM.
  always @(posedge clk) if (bus.oRdEn) bus.iRdData <= ram[bus.oRdAddr];

  always @(negedge clk) begin
    if (bus.oRdEn) addr_log.push_back(bus.oRdAddr);
    if (bus.oErr) err_cyc.push_back(cyc);
    if (bus.oDone) done_cyc.push_back(cyc);
    if (prev_dir && !bus.dirTX) dfall_cyc.push_back(cyc);
    prev_dir <= bus.dirTX;
  end

  // Serial receiver: start edge, then mid-bit samples.
  initial begin : rx_mon
    logic       ptx;
    logic [7:0] b;
    ptx = 1'b1;
    forever begin
      @(negedge clk);
      if (ptx && (bus.tx === 1'b0)) begin
        start_cyc.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        if (bus.tx !== 1'b1) stop_bad++;
        rx_byte.push_back(b);
      end
      ptx = bus.tx;
    end
  end

  initial begin : watchdog
    #(12 * 95000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_logs();
    start_cyc.delete(); err_cyc.delete(); done_cyc.delete(); dfall_cyc.delete();
    rx_byte.delete(); addr_log.delete();
    stop_bad = 0;
  endtask

  task automatic fill_ram(input bit ident);
    for (int i = 0; i < 256; i++) ram[i] = ident ? 8'(i) : 8'($urandom);
  endtask

  task automatic put_byte(input logic [7:0] b);
    bus.iData = b;
    bus.iValid = 1'b1;
    @(negedge clk);
    bus.iValid = 1'b0;
    last_iv = cyc;
  endtask

  task automatic send_req(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input int gap);
    @(negedge clk);
    put_byte(b0);
    repeat (gap - 1) @(negedge clk);
    put_byte(b1);
    repeat (gap - 1) @(negedge clk);
    put_byte(b2);
    repeat (gap - 1) @(negedge clk);
    put_byte(b3);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Expected answer: RAM[(BASE+i) mod 256], contiguous 10-bit frames.
  task automatic check_answer(input string tn, input logic [7:0] base, input int t_iv,
                              input int exp_err);
    int n;
    int gap_bad;
    logic [7:0] a;
    n = 0;
    gap_bad = 0;
    while ((done_cyc.size() == 0) && (n < 4000)) begin
      @(negedge clk);
      n++;
    end
    check_eq({tn, " done_seen"}, done_cyc.size(), 1);
    repeat (40) @(negedge clk);
    check_eq({tn, " nbytes"}, rx_byte.size(), RESP);
    check_eq({tn, " nreads"}, addr_log.size(), RESP);
    if ((rx_byte.size() == RESP) && (addr_log.size() == RESP) && (start_cyc.size() == RESP) &&
        (done_cyc.size() == 1) && (dfall_cyc.size() == 1)) begin
      for (int i = 0; i < RESP; i++) begin
        a = base + 8'(i);
        check_eq($sformatf("%s byte%0d", tn, i), int'(rx_byte[i]), int'(ram[a]));
        check_eq($sformatf("%s addr%0d", tn, i), int'(addr_log[i]), int'(a));
        if ((i > 0) && ((start_cyc[i] - start_cyc[i-1]) != BYTE_CLKS)) gap_bad++;
      end
      check_eq({tn, " byte_spacing_errs"}, gap_bad, 0);
      check_eq({tn, " first_start_lat"}, start_cyc[0] - t_iv, FIRST_LAT);
      check_eq({tn, " dir_fall_after_stop"}, dfall_cyc[0] - (start_cyc[RESP-1] + BYTE_CLKS), CPB);
      check_eq({tn, " done_at_dir_fall"}, done_cyc[0], dfall_cyc[0]);
    end
    check_eq({tn, " stop_bits_bad"}, stop_bad, 0);
    check_eq({tn, " err_pulses"}, err_cyc.size(), exp_err);
    check_eq({tn, " busy_after"}, int'(bus.oBusy), 0);
    clear_logs();
  endtask

  initial begin : main
    logic [7:0] base;
    int         anom;
    int         x;
    bus.iData  = 8'h00;
    bus.iValid = 1'b0;
    fill_ram(1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst tx", int'(bus.tx), 1);
    check_eq("rst dirTX", int'(bus.dirTX), 0);
    check_eq("rst dirRX", int'(bus.dirRX), 0);
    check_eq("rst oRdEn", int'(bus.oRdEn), 0);
    check_eq("rst oRdAddr", int'(bus.oRdAddr), 0);
    check_eq("rst busy_done_err", int'({bus.oBusy, bus.oDone, bus.oErr}), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst tx", int'(bus.tx), 1);
    check_eq("post_rst busy", int'(bus.oBusy), 0);
    clear_logs();

    // Basic request, RAM[i]=i
    send_req(8'h01, 8'h20, 8'h00, 8'h00, 160);
    check_eq("basic busy", int'(bus.oBusy), 1);
    check_answer("basic", 8'h20, last_iv, 0);

    // Address wrap
    fill_ram(1'b0);
    send_req(8'h01, 8'hF8, 8'h00, 8'h00, 160);
    check_answer("wrap", 8'hF8, last_iv, 0);

    // Address mismatch
    send_req(8'h02, 8'h20, 8'h00, 8'h00, 160);
    anom = 0;
    repeat (600) begin
      @(negedge clk);
      if ((bus.tx !== 1'b1) || (bus.dirTX !== 1'b0) || (bus.oBusy !== 1'b0)) anom++;
    end
    check_eq("mismatch line_anomalies", anom, 0);
    check_eq("mismatch errs", err_cyc.size(), 0);
    check_eq("mismatch reads", addr_log.size(), 0);
    clear_logs();

    // Inter-byte timeout, then a normal request
    @(negedge clk);
    put_byte(8'h01);
    repeat (159) @(negedge clk);
    put_byte(8'h20);
    x = last_iv;
    wait_until(x + TMO - 1);
    check_eq("timeout busy_before", int'(bus.oBusy), 1);
    check_eq("timeout no_err_early", err_cyc.size(), 0);
    wait_until(x + TMO + 10);
    check_eq("timeout err_count", err_cyc.size(), 1);
    if (err_cyc.size() == 1) check_eq("timeout err_cycle", err_cyc[0] - x, TMO);
    check_eq("timeout busy_after", int'(bus.oBusy), 0);
    clear_logs();
    base = 8'($urandom);
    send_req(8'h01, base, 8'h00, 8'h00, 160);
    check_answer("after_timeout", base, last_iv, 0);

    // Byte on the exact expiry cycle wins
    base = 8'($urandom);
    send_req(8'h01, base, 8'h55, 8'hAA, TMO);
    check_answer("expiry_race", base, last_iv, 0);

    // Collision during SEND byte 3
    fill_ram(1'b0);
    base = 8'($urandom);
    send_req(8'h01, base, 8'h00, 8'h00, 160);
    x = last_iv + FIRST_LAT + 3 * BYTE_CLKS + 50;
    wait_until(x - 1);
    put_byte(8'h01);
    @(negedge clk);
    check_eq("collision err_count", err_cyc.size(), 1);
    if (err_cyc.size() == 1) check_eq("collision err_cycle", err_cyc[0], x);
    check_answer("collision", base, x - FIRST_LAT - 3 * BYTE_CLKS - 50, 1);

    // Randomized requests
    for (int r = 0; r < 3; r++) begin
      fill_ram(1'b0);
      base = 8'($urandom);
      send_req(8'h01, base, 8'($urandom), 8'($urandom), $urandom_range(1, TMO - 1));
      check_answer($sformatf("rand%0d", r), base, last_iv, 0);
    end

    // Reset in the middle of answer byte 5
    base = 8'($urandom);
    send_req(8'h01, base, 8'h00, 8'h00, 160);
    wait_until(last_iv + FIRST_LAT + 5 * BYTE_CLKS + 40);
    check_eq("midrst driving_before", int'(bus.dirTX), 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst tx", int'(bus.tx), 1);
    check_eq("midrst dirTX", int'(bus.dirTX), 0);
    check_eq("midrst dirRX", int'(bus.dirRX), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    anom = 0;
    repeat (400) begin
      @(negedge clk);
      if ((bus.tx !== 1'b1) || (bus.dirTX !== 1'b0) || (bus.oBusy !== 1'b0)) anom++;
    end
    check_eq("midrst idle_anomalies", anom, 0);
    check_eq("midrst no_done", done_cyc.size(), 0);
    clear_logs();
    base = 8'($urandom);
    send_req(8'h01, base, 8'h00, 8'h00, 160);
    check_answer("after_midrst", base, last_iv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
